// File: rtl/fetch_unit.sv
// Instruction fetch unit: program counter, IDLE/RUN/DONE sequencing, branch flag
// and a 32-entry jump lookup table, all under asynchronous active-high reset.
module fetch_unit #(
    parameter int              PC_W     = 10,
    parameter logic [PC_W-1:0] PROG_END = 10'h3FF
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic [8:0]      Instr,
    input  logic            Jump,
    input  logic            Brc_jump,
    input  logic [4:0]      Jptr,
    input  logic            Cmp_set,
    input  logic            Cmp_val,
    input  logic            Lut_we,
    input  logic [4:0]      Lut_addr,
    input  logic [PC_W-1:0] Lut_data,
    output logic [PC_W-1:0] Prog_ctr,
    output logic [8:0]      Mach_code,
    output logic            Instr_valid,
    output logic            Busy,
    output logic            Done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [PC_W-1:0] pc_reg;
    logic [PC_W-1:0] pc_next;
    logic            flag_reg;
    logic            flag_next;

    logic [PC_W-1:0] lut_reg [32];
    logic [PC_W-1:0] jump_target;
    logic            run;

    // Jump table: read combinationally, so a same-cycle write is seen only next cycle.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 32; i++) begin
                lut_reg[i] <= '0;
            end
        end else if (Lut_we) begin
            lut_reg[Lut_addr] <= Lut_data;
        end
    end

    assign jump_target = lut_reg[Jptr];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg <= IDLE;
            pc_reg    <= '0;
            flag_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            flag_reg  <= flag_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        flag_next  = flag_reg;
        unique case (state_reg)
            IDLE, DONE: begin
                if (Start) begin
                    state_next = RUN;
                    pc_next    = '0;
                    flag_next  = 1'b0;
                end
            end
            RUN: begin
                if (Jump) begin
                    pc_next = jump_target;
                end else if (Brc_jump && flag_reg) begin
                    pc_next   = jump_target;
                    flag_next = 1'b0;
                end else if (pc_reg == PROG_END) begin
                    state_next = DONE;
                end else begin
                    pc_next = pc_reg + PC_W'(1);
                end
                // A compare result in the same cycle wins over the taken-branch clear.
                if (Cmp_set) begin
                    flag_next = Cmp_val;
                end
            end
            default: begin
                state_next = IDLE;
                pc_next    = '0;
                flag_next  = 1'b0;
            end
        endcase
    end

    assign run         = (state_reg == RUN);
    assign Busy        = run;
    assign Done        = (state_reg == DONE);
    assign Instr_valid = run;
    assign Mach_code   = run ? Instr : 9'd0;
    assign Prog_ctr    = pc_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Table-driven bench for fetch_unit (PROG_END=5); expected results queue up as
// each cycle's stimulus is driven and are checked one clock later.
module tb_fetch_unit;

    localparam int PC_W = 10;

    logic            Clk;
    logic            Reset;
    logic            Start;
    logic [8:0]      Instr;
    logic            Jump;
    logic            Brc_jump;
    logic [4:0]      Jptr;
    logic            Cmp_set;
    logic            Cmp_val;
    logic            Lut_we;
    logic [4:0]      Lut_addr;
    logic [PC_W-1:0] Lut_data;
    logic [PC_W-1:0] Prog_ctr;
    logic [8:0]      Mach_code;
    logic            Instr_valid;
    logic            Busy;
    logic            Done;

    fetch_unit #(.PC_W(PC_W), .PROG_END(10'd5)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Instr(Instr),
        .Jump(Jump), .Brc_jump(Brc_jump), .Jptr(Jptr),
        .Cmp_set(Cmp_set), .Cmp_val(Cmp_val),
        .Lut_we(Lut_we), .Lut_addr(Lut_addr), .Lut_data(Lut_data),
        .Prog_ctr(Prog_ctr), .Mach_code(Mach_code), .Instr_valid(Instr_valid),
        .Busy(Busy), .Done(Done)
    );

    // Combinational instruction memory contents.
    function automatic logic [8:0] imem(input logic [PC_W-1:0] a);
        return a[8:0] ^ 9'h0A5;
    endfunction

    assign Instr = imem(Prog_ctr);

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        logic            start;
        logic            jump;
        logic            brc;
        logic [4:0]      jptr;
        logic            cset;
        logic            cval;
        logic            we;
        logic [4:0]      waddr;
        logic [PC_W-1:0] wdata;
        logic [PC_W-1:0] pc;
        logic            busy;
        logic            done;
    } vec_t;

    typedef struct {
        logic [PC_W-1:0] pc;
        logic            busy;
        logic            done;
    } exp_t;

    vec_t tbl1[$];
    vec_t tbl2[$];
    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(input logic st, input logic j, input logic b, input int jp,
                                input logic cs, input logic cv, input logic we, input int wa,
                                input int wd, input int pc, input logic bz, input logic dn);
        vec_t v;
        v.start = st; v.jump = j; v.brc = b; v.jptr = 5'(jp);
        v.cset = cs; v.cval = cv; v.we = we; v.waddr = 5'(wa); v.wdata = PC_W'(wd);
        v.pc = PC_W'(pc); v.busy = bz; v.done = dn;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, req);
        end
    endtask

    task automatic check_outputs(input string tag, input int idx, input exp_t e);
        logic [8:0] mc;
        mc = e.busy ? imem(e.pc) : 9'd0;
        check({tag, ".pc"},    idx, 32'(Prog_ctr),    32'(e.pc));
        check({tag, ".busy"},  idx, 32'(Busy),        32'(e.busy));
        check({tag, ".done"},  idx, 32'(Done),        32'(e.done));
        check({tag, ".valid"}, idx, 32'(Instr_valid), 32'(e.busy));
        check({tag, ".mach"},  idx, 32'(Mach_code),   32'(mc));
    endtask

    task automatic step(input string tag, input int idx, input vec_t v);
        exp_t e;
        @(negedge Clk);
        Start = v.start; Jump = v.jump; Brc_jump = v.brc; Jptr = v.jptr;
        Cmp_set = v.cset; Cmp_val = v.cval;
        Lut_we = v.we; Lut_addr = v.waddr; Lut_data = v.wdata;
        e.pc = v.pc; e.busy = v.busy; e.done = v.done;
        exp_q.push_back(e);
        @(posedge Clk);
        #1;
        e = exp_q.pop_front();
        check_outputs(tag, idx, e);
        $display("[TB] %s step %0d: pc=%0d busy=%0b done=%0b mach=%0h", tag, idx, Prog_ctr, Busy, Done, Mach_code);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t er;
        Reset = 1'b1; Start = 0; Jump = 0; Brc_jump = 0; Jptr = '0;
        Cmp_set = 0; Cmp_val = 0; Lut_we = 0; Lut_addr = '0; Lut_data = '0;

        //             st j  b  jp cs cv we wa wd    pc  bz dn
        tbl1.push_back(mk(0,0,0,0, 0,0,1,3,40,   0,  0,0)); // table loads in IDLE
        tbl1.push_back(mk(0,0,0,0, 0,0,1,1,20,   0,  0,0));
        tbl1.push_back(mk(0,0,0,0, 0,0,1,2,30,   0,  0,0));
        tbl1.push_back(mk(0,0,0,0, 0,0,1,4,7,    0,  0,0));
        tbl1.push_back(mk(0,0,0,0, 0,0,1,5,1023, 0,  0,0));
        tbl1.push_back(mk(0,0,0,0, 0,0,1,6,10,   0,  0,0));
        tbl1.push_back(mk(0,0,0,0, 0,0,1,7,2,    0,  0,0));
        tbl1.push_back(mk(0,1,0,3, 0,0,0,0,0,    0,  0,0)); // jump ignored in IDLE
        tbl1.push_back(mk(1,0,0,0, 0,0,0,0,0,    0,  1,0)); // sequential run
        tbl1.push_back(mk(0,0,0,0, 0,0,0,0,0,    1,  1,0));
        tbl1.push_back(mk(0,0,0,0, 0,0,0,0,0,    2,  1,0));
        tbl1.push_back(mk(0,0,0,0, 0,0,0,0,0,    3,  1,0));
        tbl1.push_back(mk(0,0,0,0, 0,0,0,0,0,    4,  1,0));
        tbl1.push_back(mk(0,0,0,0, 0,0,0,0,0,    5,  1,0));
        tbl1.push_back(mk(0,0,0,0, 0,0,0,0,0,    5,  0,1)); // DONE after PROG_END
        tbl1.push_back(mk(0,0,0,0, 0,0,0,0,0,    5,  0,1));
        tbl1.push_back(mk(0,1,0,3, 0,0,0,0,0,    5,  0,1)); // jump ignored in DONE
        tbl1.push_back(mk(1,0,0,0, 0,0,0,0,0,    0,  1,0)); // restart
        tbl1.push_back(mk(1,0,0,0, 1,1,0,0,0,    1,  1,0)); // Start in RUN ignored; flag=1
        tbl1.push_back(mk(0,0,0,0, 0,0,0,0,0,    2,  1,0));
        tbl1.push_back(mk(0,0,0,0, 0,0,0,0,0,    3,  1,0));
        tbl1.push_back(mk(0,0,0,0, 0,0,0,0,0,    4,  1,0));
        tbl1.push_back(mk(0,0,0,0, 0,0,0,0,0,    5,  1,0));
        tbl1.push_back(mk(0,0,0,0, 0,0,0,0,0,    5,  0,1));
        tbl1.push_back(mk(1,0,0,0, 0,0,0,0,0,    0,  1,0)); // restart clears flag
        tbl1.push_back(mk(0,0,1,1, 0,0,0,0,0,    1,  1,0)); // brc not taken
        tbl1.push_back(mk(0,1,0,4, 0,0,0,0,0,    7,  1,0));
        tbl1.push_back(mk(0,1,0,3, 0,0,0,0,0,    40, 1,0)); // unconditional jump
        tbl1.push_back(mk(0,0,0,0, 0,0,0,0,0,    41, 1,0));
        tbl1.push_back(mk(0,0,0,0, 1,0,0,0,0,    42, 1,0)); // flag=0
        tbl1.push_back(mk(0,0,1,1, 0,0,0,0,0,    43, 1,0));
        tbl1.push_back(mk(0,0,0,0, 1,1,0,0,0,    44, 1,0)); // flag=1
        tbl1.push_back(mk(0,0,1,1, 0,0,0,0,0,    20, 1,0)); // taken, flag cleared
        tbl1.push_back(mk(0,0,1,1, 0,0,0,0,0,    21, 1,0)); // second brc not taken
        tbl1.push_back(mk(0,0,0,0, 1,1,0,0,0,    22, 1,0));
        tbl1.push_back(mk(0,1,1,3, 0,0,0,0,0,    40, 1,0)); // jump+brc: flag kept
        tbl1.push_back(mk(0,0,1,1, 0,0,0,0,0,    20, 1,0));
        tbl1.push_back(mk(0,0,0,0, 1,1,0,0,0,    21, 1,0));
        tbl1.push_back(mk(0,0,1,1, 1,1,0,0,0,    20, 1,0)); // taken + cmp_set: flag=1
        tbl1.push_back(mk(0,0,1,1, 0,0,0,0,0,    20, 1,0));
        tbl1.push_back(mk(0,0,1,1, 0,0,0,0,0,    21, 1,0));
        tbl1.push_back(mk(0,1,0,2, 0,0,1,2,9,    30, 1,0)); // write vs read: old entry
        tbl1.push_back(mk(0,1,0,2, 0,0,0,0,0,    9,  1,0));
        tbl1.push_back(mk(0,1,0,7, 0,0,0,0,0,    2,  1,0));
        tbl1.push_back(mk(0,0,0,0, 0,0,0,0,0,    3,  1,0));
        tbl1.push_back(mk(0,0,0,0, 0,0,0,0,0,    4,  1,0));
        tbl1.push_back(mk(0,0,0,0, 0,0,0,0,0,    5,  1,0));
        tbl1.push_back(mk(0,1,0,3, 0,0,0,0,0,    40, 1,0)); // jump at PROG_END stays in RUN
        tbl1.push_back(mk(0,1,0,5, 0,0,0,0,0,    1023,1,0));
        tbl1.push_back(mk(0,0,0,0, 0,0,0,0,0,    0,  1,0)); // wrap to 0
        tbl1.push_back(mk(0,0,0,0, 0,0,0,0,0,    1,  1,0));
        tbl1.push_back(mk(0,1,0,6, 0,0,0,0,0,    10, 1,0));
        tbl1.push_back(mk(0,0,0,0, 0,0,0,0,0,    11, 1,0));
        tbl1.push_back(mk(0,0,0,0, 0,0,0,0,0,    12, 1,0));

        tbl2.push_back(mk(0,0,0,0, 0,0,0,0,0,    0,  0,0)); // stays IDLE after reset
        tbl2.push_back(mk(0,0,0,0, 0,0,0,0,0,    0,  0,0));
        tbl2.push_back(mk(1,0,0,0, 0,0,0,0,0,    0,  1,0));
        tbl2.push_back(mk(0,1,0,3, 0,0,0,0,0,    0,  1,0)); // table cleared by reset
        tbl2.push_back(mk(0,0,0,0, 0,0,0,0,0,    1,  1,0));
        tbl2.push_back(mk(0,1,0,5, 0,0,0,0,0,    0,  1,0));

        // Outputs while reset is held.
        #2;
        er.pc = '0; er.busy = 0; er.done = 0;
        check_outputs("reset", 0, er);
        @(negedge Clk);
        Reset = 1'b0;

        foreach (tbl1[i]) step("main", i, tbl1[i]);

        // Asynchronous reset between edges at PC=12.
        #3;
        Reset = 1'b1;
        #1;
        er.pc = '0; er.busy = 0; er.done = 0;
        check_outputs("async_rst", 0, er);
        $display("[TB] async_rst: pc=%0d busy=%0b done=%0b valid=%0b", Prog_ctr, Busy, Done, Instr_valid);
        @(negedge Clk);
        Reset = 1'b0;
        Start = 0; Jump = 0; Brc_jump = 0; Cmp_set = 0; Lut_we = 0;

        foreach (tbl2[i]) step("post_rst", i, tbl2[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter PC_W, default 10, meaning program counter width in bits.
REQ-002 The block SHALL have parameter PROG_END, default 10'h3FF, meaning address of the last program instruction.
REQ-003 The block SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port Start, input, 1 bit: level sampled per cycle; launches program execution.
REQ-006 The block SHALL have port Instr, input, 9 bits: instruction-memory read data for address Prog_ctr (combinational memory).
REQ-007 The block SHALL have port Jump, input, 1 bit: unconditional jump request from decode.
REQ-008 The block SHALL have port Brc_jump, input, 1 bit: conditional jump request, taken only when the branch flag is set.
REQ-009 The block SHALL have port Jptr, input, 5 bits: jump lookup-table index.
REQ-010 The block SHALL have port Cmp_set, input, 1 bit: strobe from blt/beq execution that loads the branch flag.
REQ-011 The block SHALL have port Cmp_val, input, 1 bit: comparison result loaded when Cmp_set=1.
REQ-012 The block SHALL have ports Lut_we (input, 1 bit), Lut_addr (input, 5 bits) and Lut_data (input, PC_W bits): lookup-table write port.
REQ-013 The block SHALL have port Prog_ctr, output, PC_W bits: registered program counter, the instruction-memory address.
REQ-014 The block SHALL have port Mach_code, output, 9 bits: instruction to decode.
REQ-015 The block SHALL have port Instr_valid, output, 1 bit: Mach_code is valid this cycle.
REQ-016 The block SHALL have ports Busy (output, 1 bit) and Done (output, 1 bit): program running and program finished, respectively.

Function
REQ-017 The block SHALL implement three states, IDLE, RUN and DONE; Busy=1 only in RUN and Done=1 only in DONE, both decoded from registered state.
REQ-018 In IDLE, Start=1 SHALL move the block to RUN with Prog_ctr=0 and the branch flag cleared on that edge.
REQ-019 In DONE, Start=1 SHALL move the block to RUN with Prog_ctr=0 and the flag cleared; otherwise DONE SHALL hold and Prog_ctr SHALL be frozen.
REQ-020 In RUN, Start SHALL be ignored.
REQ-021 Mach_code SHALL equal Instr and Instr_valid SHALL be 1 while in RUN; in IDLE and DONE, Mach_code SHALL be 0 and Instr_valid SHALL be 0, with downstream gating its writes on Instr_valid.
REQ-022 In RUN, the next PC SHALL be chosen with this priority: Jump=1 gives LUT[Jptr]; otherwise Brc_jump=1 with flag=1 gives LUT[Jptr] and clears the flag; otherwise Prog_ctr+1, including the case Brc_jump=1 with flag=0.
REQ-023 Jump=1 and Brc_jump=1 in the same cycle SHALL be treated as Jump, leaving the flag unchanged.
REQ-024 In RUN with Prog_ctr==PROG_END and no taken jump, the block SHALL enter DONE on the next edge and Prog_ctr SHALL hold PROG_END.
REQ-025 In RUN with Prog_ctr==PROG_END and a taken jump, the block SHALL stay in RUN and Prog_ctr SHALL load the jump target.
REQ-026 The increment SHALL be modulo 2^PC_W, so all-ones wraps to 0 when PROG_END is not all-ones.
REQ-027 Cmp_set=1 in RUN SHALL make flag<=Cmp_val.
REQ-028 A taken Brc_jump SHALL evaluate the pre-edge flag; when Cmp_set=1 in the same cycle, the flag SHALL take Cmp_val rather than being cleared.
REQ-029 Jump, Brc_jump and Cmp_set SHALL be ignored outside RUN.
REQ-030 The jump lookup table SHALL hold 32 entries of PC_W bits.
REQ-031 Lut_we=1 SHALL write Lut_data to LUT[Lut_addr] at the edge in any state.
REQ-032 A jump reading the LUT entry being written in the same cycle SHALL use the old entry.
REQ-033 A taken jump SHALL take one cycle: the target instruction is presented on the next cycle, with no bubble and no delay slot.

Reset
REQ-034 Reset=1 SHALL asynchronously force state=IDLE, Prog_ctr=0, flag=0 and all LUT entries=0.
REQ-035 While Reset=1, the outputs SHALL be Busy=0, Done=0, Instr_valid=0 and Mach_code=0.
REQ-036 Reset asserted mid-RUN SHALL abort the program with no DONE pulse; after release, a new Start SHALL be required.

Verification
REQ-037 Sequential run: with PROG_END=5, pulse Start and hold Jump, Brc_jump and Cmp_set at 0 -> Prog_ctr=0,1,2,3,4,5; Done=1 on the cycle after PC=5; Prog_ctr held at 5.
REQ-038 Unconditional jump: write LUT[3]=40; in RUN at PC=7, assert Jump with Jptr=3 -> next Prog_ctr=40, then 41.
REQ-039 Conditional jump: with LUT[1]=20, apply Cmp_set=1 with Cmp_val=0, then Brc_jump with Jptr=1 -> PC+1. Repeat with Cmp_val=1 -> PC=20 and flag=0 afterwards; an immediate second Brc_jump SHALL not be taken.
REQ-040 Simultaneous events: apply Jump+Brc_jump with flag=1 -> Jump target taken and flag stays 1. Apply Brc_jump taken with Cmp_set=1 and Cmp_val=1 -> jump taken and flag=1. Apply Lut_we to LUT[2]=9 while jumping via Jptr=2 holding 30 -> PC=30.
REQ-041 Reset mid-RUN: assert Reset asynchronously between edges at PC=12 -> immediately Prog_ctr=0, Busy=0, Instr_valid=0, LUT[*]=0; stays in IDLE until Start.
REQ-042 Restart from DONE: pulse Start while in DONE -> RUN with Prog_ctr=0 and flag=0; Start in RUN SHALL not disturb Prog_ctr.
